marquee_shifter: RTL and testbench

Parametrised marquee engine for LED and seven-segment demos: a WIDTH-bit register with its own step prescaler, parallel load, and four motion modes (shift, rotate, bounce, hold). It replaces the fixed 8-bit shift register and its separate 1 s clock divider. It runs on the board clock, so no derived clocks are needed. `q` drives LEDs or display digits directly.

---
 rtl/marquee_pkg.sv | 18 +
 rtl/marquee_shifter_step_gen.sv | 42 ++++
 rtl/marquee_shifter.sv | 147 ++++++++++++++
 tb/tb_marquee_shifter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/marquee_pkg.sv
// marquee_pkg
// Shared constants for the marquee engine.
//   mode_e    : motion mode encoding as seen on the `mode` port
//   DIR_LEFT  : shift toward the MSB
//   DIR_RIGHT : shift toward the LSB
package marquee_pkg;

  typedef enum logic [1:0] {
    MODE_SHIFT  = 2'b00,
    MODE_ROTATE = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/marquee_shifter_step_gen.sv
// step_gen
// Step prescaler for the marquee engine. It counts board clocks while `run`
// is high and flags the cycle in which the count sits at DIV-1.
// Ports:
//   clk   in  : board clock
//   rst_n in  : asynchronous active-low reset
//   run   in  : count enable; the count holds while low
//   clr   in  : synchronous restart of the count at 0 (parallel load)
//   tick  out : high during the cycle whose rising edge is a step edge
module step_gen #(
  parameter int DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // With DIV=1 the count stays at 0 == LAST, so every running edge is a step.
  assign tick = run && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (run) begin
      if (cnt == LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/marquee_shifter.sv
// marquee_shifter
// WIDTH-bit marquee register with its own step prescaler, parallel load and
// four motion modes (shift, rotate, bounce, hold). Runs on the board clock.
// Configuration macro: MARQUEE_BOUNCE_EN
//   defined     : bounce mode implemented, dir_o follows the bounce direction
//   not defined : no direction register, mode 10 acts as hold, dir_o = 0
// Ports:
//   clk   in         : board clock
//   rst_n in         : asynchronous active-low reset
//   load  in         : parallel load request (beats any step on the same edge)
//   pin   in [WIDTH] : parallel load data
//   mode  in [2]     : 00 shift, 01 rotate, 10 bounce, 11 hold
//   dir   in         : 0 left (toward MSB), 1 right; initial bounce direction
//   sin   in         : serial fill bit for shift mode
//   run   in         : prescaler enable
//   q     out[WIDTH] : pattern
//   step  out        : one-cycle pulse after each step edge
//   dir_o out        : current bounce direction
module marquee_shifter
  import marquee_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 50_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] pin,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic             sin,
  input  logic             run,
  output logic [WIDTH-1:0] q,
  output logic             step,
  output logic             dir_o
);

  logic             tick;
  logic [WIDTH-1:0] q_next;

  step_gen #(
    .DIV(DIV)
  ) u_step_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (run),
    .clr  (load),
    .tick (tick)
  );

`ifdef MARQUEE_BOUNCE_EN
  logic dir_r;
  logic dir_next;
  logic lead_bit;
  logic opp_bit;

  // End bit in the direction of travel, and the one at the far end.
  assign lead_bit = (dir_r == DIR_RIGHT) ? q[0] : q[WIDTH-1];
  assign opp_bit  = (dir_r == DIR_RIGHT) ? q[WIDTH-1] : q[0];
  assign dir_o    = dir_r;
`else
  assign dir_o = 1'b0;
`endif

  always_comb begin
    q_next = q;
`ifdef MARQUEE_BOUNCE_EN
    dir_next = dir_r;
`endif
    case (mode)
      MODE_SHIFT: begin
        if (dir == DIR_RIGHT) begin
          q_next = {sin, q[WIDTH-1:1]};
        end else begin
          q_next = {q[WIDTH-2:0], sin};
        end
      end
      MODE_ROTATE: begin
        if (dir == DIR_RIGHT) begin
          q_next = {q[0], q[WIDTH-1:1]};
        end else begin
          q_next = {q[WIDTH-2:0], q[WIDTH-1]};
        end
      end
      MODE_BOUNCE: begin
`ifdef MARQUEE_BOUNCE_EN
        // An empty pattern neither moves nor turns around. Hitting an end
        // reverses immediately and moves in the new direction on the same
        // step, unless the far end is also occupied, in which case it only
        // turns around.
        if (q != '0) begin
          if (!lead_bit) begin
            if (dir_r == DIR_RIGHT) begin
              q_next = {1'b0, q[WIDTH-1:1]};
            end else begin
              q_next = {q[WIDTH-2:0], 1'b0};
            end
          end else if (!opp_bit) begin
            dir_next = ~dir_r;
            if (dir_r == DIR_RIGHT) begin
              q_next = {q[WIDTH-2:0], 1'b0};
            end else begin
              q_next = {1'b0, q[WIDTH-1:1]};
            end
          end else begin
            dir_next = ~dir_r;
          end
        end
`else
        q_next = q;
`endif
      end
      default: begin
        q_next = q;
      end
    endcase
  end

  // A load restarts the prescaler and suppresses the step on that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= '0;
      step <= 1'b0;
    end else if (load) begin
      q    <= pin;
      step <= 1'b0;
    end else if (tick) begin
      q    <= q_next;
      step <= 1'b1;
    end else begin
      step <= 1'b0;
    end
  end

`ifdef MARQUEE_BOUNCE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_r <= DIR_LEFT;
    end else if (load) begin
      dir_r <= dir;
    end else if (tick) begin
      dir_r <= dir_next;
    end
  end
`endif

endmodule

// File: tb/tb_marquee_shifter.sv
// tb_marquee_shifter
// Scoreboard bench for marquee_shifter with WIDTH=8, DIV=4. The driver
// pushes the predicted {q, step, dir_o} for every clock edge; a monitor
// pops and compares shortly after each rising edge.
// Follows MARQUEE_BOUNCE_EN in the same way as the design.
module tb_marquee_shifter;

  localparam int WIDTH = 8;
  localparam int DIV   = 4;

`ifdef MARQUEE_BOUNCE_EN
  localparam bit BOUNCE_EN = 1'b1;
`else
  localparam bit BOUNCE_EN = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       load  = 1'b0;
  logic [7:0] pin   = 8'h00;
  logic [1:0] mode  = 2'b00;
  logic       dir   = 1'b0;
  logic       sin   = 1'b0;
  logic       run   = 1'b0;
  logic [7:0] q;
  logic       step;
  logic       dir_o;

  marquee_shifter #(
    .WIDTH(WIDTH),
    .DIV  (DIV)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .pin  (pin),
    .mode (mode),
    .dir  (dir),
    .sin  (sin),
    .run  (run),
    .q    (q),
    .step (step),
    .dir_o(dir_o)
  );

  always #5 clk = ~clk;

  int n_compared = 0;
  int n_failed   = 0;

  logic [9:0] sb[$];

  // Reference state: pattern, prescaler position, bounce direction, pulse.
  bit [7:0] mq    = 8'h00;
  int       mcnt  = 0;
  bit       mdir  = 1'b0;
  bit       mstep = 1'b0;

  task automatic checkOutput(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_failed++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic void modelMove();
    bit lead;
    bit opp;
    case (mode)
      2'b00: mq = dir ? ((mq >> 1) | (8'(sin) << 7)) : ((mq << 1) | 8'(sin));
      2'b01: mq = dir ? ((mq >> 1) | (mq << 7)) : ((mq << 1) | (mq >> 7));
      2'b10: begin
        if (BOUNCE_EN && mq != 8'h00) begin
          lead = mdir ? mq[0] : mq[7];
          opp  = mdir ? mq[7] : mq[0];
          if (lead) mdir = ~mdir;
          if (!(lead && opp)) mq = mdir ? (mq >> 1) : (mq << 1);
        end
      end
      default: ;
    endcase
  endfunction

  function automatic void modelEdge();
    if (!rst_n) begin
      mq = 8'h00; mcnt = 0; mdir = 1'b0; mstep = 1'b0;
    end else if (load) begin
      mq = pin; mcnt = 0; mdir = BOUNCE_EN ? dir : 1'b0; mstep = 1'b0;
    end else if (run && mcnt == DIV - 1) begin
      mcnt = 0; mstep = 1'b1;
      modelMove();
    end else begin
      if (run) mcnt++;
      mstep = 1'b0;
    end
  endfunction

  // One clock of stimulus: drive at the falling edge, predict the next edge.
  task automatic applyStimulus(input logic r, input logic ld, input logic [7:0] p,
                               input logic [1:0] md, input logic d, input logic s,
                               input logic rn);
    @(negedge clk);
    rst_n = r; load = ld; pin = p; mode = md; dir = d; sin = s; run = rn;
    modelEdge();
    sb.push_back({mq, mstep, mdir});
  endtask

  task automatic idle(input int n, input logic rn);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, pin, mode, dir, sin, rn);
  endtask

  task automatic checkNow(input string name, input logic [7:0] exp_q);
    @(posedge clk);
    #2;
    checkOutput(name, {2'b00, q}, {2'b00, exp_q});
  endtask

  task automatic midReset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", {q, step, dir_o}, 10'h000);
    mq = 8'h00; mcnt = 0; mdir = 1'b0; mstep = 1'b0;
  endtask

  // Monitor: every edge with a pending prediction is compared.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) checkOutput("cycle", {q, step, dir_o}, sb.pop_front());
    end
  end

  initial begin
    $display("[TB] marquee_shifter WIDTH=%0d DIV=%0d bounce=%0d", WIDTH, DIV, BOUNCE_EN);

    // Reset, then nothing moves with run low.
    applyStimulus(1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0);
    idle(6, 1'b0);

    // Shift left with sin=1.
    applyStimulus(1'b1, 1'b1, 8'h81, 2'b00, 1'b0, 1'b1, 1'b1);
    idle(4, 1'b1);
    checkNow("shift_left_4", 8'h03);
    idle(4, 1'b1);
    checkNow("shift_left_8", 8'h07);
    idle(2, 1'b1);

    // Reset arriving mid-count, then quiet with run low.
    midReset();
    applyStimulus(1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0);
    idle(5, 1'b0);

    // Rotate right, with a 10-cycle run gap between steps.
    applyStimulus(1'b1, 1'b1, 8'h01, 2'b01, 1'b1, 1'b0, 1'b1);
    idle(4, 1'b1);
    checkNow("rotate_right_1", 8'h80);
    idle(2, 1'b1);
    idle(10, 1'b0);
    idle(2, 1'b1);
    checkNow("rotate_right_2", 8'h40);
    idle(4, 1'b1);
    checkNow("rotate_right_3", 8'h20);

    // Bounce starting leftward from 40.
    applyStimulus(1'b1, 1'b1, 8'h40, 2'b10, 1'b0, 1'b0, 1'b1);
    idle(4, 1'b1);
    checkNow("bounce_1", BOUNCE_EN ? 8'h80 : 8'h40);
    idle(4, 1'b1);
    checkNow("bounce_2", 8'h40);
    idle(4 * 8, 1'b1);

    // Bounce with both end bits set.
    applyStimulus(1'b1, 1'b1, 8'h81, 2'b10, 1'b0, 1'b0, 1'b1);
    idle(4 * 4, 1'b1);
    checkNow("bounce_both_ends", 8'h81);

    // Load on the edge where the prescaler sits at DIV-1.
    applyStimulus(1'b1, 1'b1, 8'h01, 2'b00, 1'b0, 1'b0, 1'b1);
    idle(3, 1'b1);
    applyStimulus(1'b1, 1'b1, 8'hF0, 2'b00, 1'b0, 1'b0, 1'b1);
    checkNow("load_collision", 8'hF0);
    idle(4, 1'b1);
    checkNow("after_collision", 8'hE0);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 99) != 0),
                    ($urandom_range(0, 24) == 0),
                    8'($urandom),
                    2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) != 0));
    end

    repeat (3) @(posedge clk);
    #2;
    checkOutput("scoreboard_drained", 10'(sb.size()), 10'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
